// File: rtl/hazard_scoreboard.sv
// Parametrised forwarding/hazard scoreboard for the in-order RV32I pipeline.
// Optional stall statistics counter enabled by HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs0,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs0_used,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      ex_fwd_sel_0,
    output logic [SEL_W-1:0]      ex_fwd_sel_1,
    output logic                  busy,
    output logic [15:0]           stall_count
);

    logic [DEPTH:1]                 ent_v_r;
    logic [DEPTH:1][REG_ADDR_W-1:0] ent_rd_r;
    logic [DEPTH:1]                 ent_ld_r;

    logic [SEL_W-1:0] match_0_s;
    logic [SEL_W-1:0] match_1_s;
    logic             hazard_0_s;
    logic             hazard_1_s;
    logic             iss_s;
    logic             new_v_s;

    // Smallest matching index wins, so scan from oldest to youngest and overwrite.
    function automatic logic [SEL_W-1:0] youngest_match(
        input logic                           used,
        input logic [REG_ADDR_W-1:0]          rs,
        input logic [DEPTH:1]                 v,
        input logic [DEPTH:1][REG_ADDR_W-1:0] rd
    );
        logic [SEL_W-1:0] sel;
        sel = {SEL_W{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (rs != {REG_ADDR_W{1'b0}}) && v[k] && (rd[k] == rs)) begin
                sel = SEL_W'(k);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // A load matched before its data exists cannot be forwarded yet.
    function automatic logic load_not_ready(
        input logic [SEL_W-1:0] sel,
        input logic [DEPTH:1]   ld
    );
        logic h;
        h = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
                h = ld[k] && (k < LOAD_LAT + 1);
            end else begin
                h = h;
            end
        end
        return h;
    endfunction

    // Operand lookup, stall and issue qualification for the ID instruction.
    always_comb begin
        match_0_s  = youngest_match(id_rs0_used, id_rs0, ent_v_r, ent_rd_r);
        match_1_s  = youngest_match(id_rs1_used, id_rs1, ent_v_r, ent_rd_r);
        hazard_0_s = load_not_ready(match_0_s, ent_ld_r);
        hazard_1_s = load_not_ready(match_1_s, ent_ld_r);
        if (id_valid && !flush) begin
            stall = hazard_0_s || hazard_1_s;
        end else begin
            stall = 1'b0;
        end
        iss_s   = id_valid && !flush && !stall;
        new_v_s = iss_s && id_reg_write && (id_rd != {REG_ADDR_W{1'b0}});
    end

    // In-flight destination shift register; entries past DEPTH fall off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_v_r  <= {DEPTH{1'b0}};
            ent_rd_r <= {(DEPTH*REG_ADDR_W){1'b0}};
            ent_ld_r <= {DEPTH{1'b0}};
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent_v_r[k]  <= ent_v_r[k-1];
                ent_rd_r[k] <= ent_rd_r[k-1];
                ent_ld_r[k] <= ent_ld_r[k-1];
            end
            ent_v_r[1]  <= new_v_s;
            ent_rd_r[1] <= id_rd;
            ent_ld_r[1] <= id_is_load;
        end
    end

    // Forwarding selects follow the instruction into EX; bubbles get zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_fwd_sel_0 <= {SEL_W{1'b0}};
            ex_fwd_sel_1 <= {SEL_W{1'b0}};
        end else if (iss_s) begin
            ex_fwd_sel_0 <= match_0_s;
            ex_fwd_sel_1 <= match_1_s;
        end else begin
            ex_fwd_sel_0 <= {SEL_W{1'b0}};
            ex_fwd_sel_1 <= {SEL_W{1'b0}};
        end
    end

    assign busy = |ent_v_r;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] stall_count_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_r <= 16'h0000;
        end else if (stall && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: default (2/1) and deep (4/2) instances.
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs0, id_rs1, id_rd;
    logic       id_rs0_used, id_rs1_used, id_reg_write, id_is_load, flush;

    logic        stall_a, busy_a;
    logic [1:0]  sel0_a, sel1_a;
    logic [15:0] cnt_a;
    logic        stall_b, busy_b;
    logic [2:0]  sel0_b, sel1_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(2), .LOAD_LAT(1)) dut_a (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_a), .ex_fwd_sel_0(sel0_a), .ex_fwd_sel_1(sel1_a),
        .busy(busy_a), .stall_count(cnt_a)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(4), .LOAD_LAT(2)) dut_b (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_b), .ex_fwd_sel_0(sel0_b), .ex_fwd_sel_1(sel1_b),
        .busy(busy_b), .stall_count(cnt_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs0, input logic u0,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs0 = rs0; id_rs0_used = u0; id_rs1 = rs1; id_rs1_used = u1;
        id_rd = rd; id_reg_write = we; id_is_load = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [15:0] exp_cnt1, exp_cnt2;

    initial begin
`ifdef HAZARD_SCOREBOARD_STATS_EN
        exp_cnt1 = 16'd1;
        exp_cnt2 = 16'd2;
`else
        exp_cnt1 = 16'd0;
        exp_cnt2 = 16'd0;
`endif
        reset = 1'b0;
        do_reset();
        check("rst_stall", {15'd0, stall_a}, 16'd0);
        check("rst_sel0", {14'd0, sel0_a}, 16'd0);
        check("rst_sel1", {14'd0, sel1_a}, 16'd0);
        check("rst_busy", {15'd0, busy_a}, 16'd0);
        check("rst_cnt", cnt_a, 16'd0);
        check("rst_busy_b", {15'd0, busy_b}, 16'd0);

        // ALU dependency: add x5 ; sub x6, x5, x1
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        #1 check("alu_stall_add", {15'd0, stall_a}, 16'd0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1 check("alu_stall_sub", {15'd0, stall_a}, 16'd0);
        check("alu_busy", {15'd0, busy_a}, 16'd1);
        tick();
        idle();
        check("alu_sel0", {14'd0, sel0_a}, 16'd1);
        check("alu_sel1", {14'd0, sel1_a}, 16'd0);

        // Load-use: lw x7 ; add x8, x7, x7
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        #1 check("lu_stall1", {15'd0, stall_a}, 16'd1);
        tick();
        check("lu_bubble_sel0", {14'd0, sel0_a}, 16'd0);
        #1 check("lu_stall2", {15'd0, stall_a}, 16'd0);
        tick();
        idle();
        check("lu_sel0", {14'd0, sel0_a}, 16'd2);
        check("lu_sel1", {14'd0, sel1_a}, 16'd2);
        check("lu_cnt", cnt_a, exp_cnt1);

        // Youngest wins: addi x3 ; addi x3 ; or x4, x3, x0
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        #1 check("yw_stall", {15'd0, stall_a}, 16'd0);
        tick();
        idle();
        check("yw_sel0", {14'd0, sel0_a}, 16'd1);
        check("yw_sel1", {14'd0, sel1_a}, 16'd0);

        // Flush priority: lw x9 ; add x10, x9, x0 flushed in ID
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
        flush = 1'b1;
        #1 check("fl_stall", {15'd0, stall_a}, 16'd0);
        tick();
        idle();
        check("fl_sel0", {14'd0, sel0_a}, 16'd0);
        check("fl_sel1", {14'd0, sel1_a}, 16'd0);
        tick();
        check("fl_e1_empty", {15'd0, busy_a}, 16'd0);

        // Deep pipeline: lw x12 ; add x13, x12, x0
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0);
        #1 check("dp_stall1", {15'd0, stall_b}, 16'd1);
        tick();
        check("dp_stall2", {15'd0, stall_b}, 16'd1);
        tick();
        check("dp_stall3", {15'd0, stall_b}, 16'd0);
        tick();
        idle();
        check("dp_sel0", {13'd0, sel0_b}, 16'd3);
        check("dp_sel1", {13'd0, sel1_b}, 16'd0);
        check("dp_cnt", cnt_b, exp_cnt2);

        // Deep pipeline: producer x20 seen from E[4], then gone
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        drive(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("dp_old4_sel0", {13'd0, sel0_b}, 16'd4);
        tick();
        idle();
        check("dp_gone_sel0", {13'd0, sel0_b}, 16'd0);

        // Reset in the middle of a load-use stall
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        #1 check("rs_pre_sel0", {14'd0, sel0_a}, 16'd1);
        check("rs_pre_stall", {15'd0, stall_a}, 16'd1);
        reset = 1'b1;
        #1 check("rs_stall", {15'd0, stall_a}, 16'd0);
        check("rs_sel0", {14'd0, sel0_a}, 16'd0);
        check("rs_busy", {15'd0, busy_a}, 16'd0);
        check("rs_cnt", cnt_a, 16'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        idle();
        check("rs_re_sel0", {14'd0, sel0_a}, 16'd0);
        check("rs_re_sel1", {14'd0, sel1_a}, 16'd0);
        check("rs_re_busy", {15'd0, busy_a}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
